decode_fwd_stage: RTL and testbench

//  Parametrised Y86-64 pipeline decode stage: register file with synchronous reset, dual write ports,

---
 rtl/y86_pkg.sv | 33 +++
 rtl/y86_regfile.sv | 45 ++++
 rtl/decode_fwd_stage.sv | 192 +++++++++++++++++++
 tb/tb_decode_fwd_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, register indices and status codes.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Register indices
  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  // Status codes
  localparam logic [2:0] SAOK = 3'h1;
  localparam logic [2:0] SHLT = 3'h2;
  localparam logic [2:0] SADR = 3'h3;
  localparam logic [2:0] SINS = 3'h4;

  // Instructions whose dstM is only known after the memory stage.
  function automatic logic is_load(input logic [3:0] icode);
    return (icode == IMRMOVQ) || (icode == IPOPQ);
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register file: NREG x XLEN, two combinational read ports, two write ports.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   raddr_a/raddr_b     read indices; out-of-range (incl. RNONE) reads return 0
//   rdata_a/rdata_b     read data (pre-edge contents)
//   wdst_e/wval_e       write port 0
//   wdst_m/wval_m       write port 1; wins over port 0 on the same index
module y86_regfile
  import y86_pkg::*;
#(
  parameter int unsigned      XLEN    = 64,
  parameter int unsigned      NREG    = 15,
  parameter logic [XLEN-1:0]  RSP_RST = XLEN'(255)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      raddr_a,
  input  logic [3:0]      raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b,
  input  logic [3:0]      wdst_e,
  input  logic [XLEN-1:0] wval_e,
  input  logic [3:0]      wdst_m,
  input  logic [XLEN-1:0] wval_m
);

  logic [XLEN-1:0] regs_q [NREG];

  // Index RNONE is never matched because NREG <= 15 keeps i below 4'hF.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (rst) begin
        regs_q[i] <= (4'(i) == RRSP) ? RSP_RST : '0;
      end else if (wdst_m == 4'(i)) begin
        regs_q[i] <= wval_m;
      end else if (wdst_e == 4'(i)) begin
        regs_q[i] <= wval_e;
      end
    end
  end

  assign rdata_a = (32'(raddr_a) < NREG) ? regs_q[raddr_a] : '0;
  assign rdata_b = (32'(raddr_b) < NREG) ? regs_q[raddr_b] : '0;

endmodule

// File: rtl/decode_fwd_stage.sv
// Y86-64 decode stage: register source/destination decode, five-source operand forwarding,
// load/use hazard detection and the D->E pipeline register with stall/bubble control.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   D_*                       fields from the D pipeline register
//   e_dstE/e_valE             execute-stage result (highest forwarding priority)
//   M_dstM/m_valM, M_dstE/M_valE  memory-stage forwarding sources
//   W_dstM/W_valM, W_dstE/W_valE  writeback sources, also the register-file write ports
//   E_stall, E_bubble         E register hold / NOP injection (bubble wins)
//   d_srcA, d_srcB            combinational source registers for the hazard unit
//   load_use                  E holds a load whose dstM feeds the instruction in decode
//   E_*                       registered E pipeline register contents
module decode_fwd_stage
  import y86_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned NREG    = 15,
  parameter int unsigned RSP_RST = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      D_stat,
  input  logic [3:0]      D_icode,
  input  logic [3:0]      D_ifun,
  input  logic [3:0]      D_rA,
  input  logic [3:0]      D_rB,
  input  logic [XLEN-1:0] D_valC,
  input  logic [XLEN-1:0] D_valP,
  input  logic [3:0]      e_dstE,
  input  logic [XLEN-1:0] e_valE,
  input  logic [3:0]      M_dstM,
  input  logic [XLEN-1:0] m_valM,
  input  logic [3:0]      M_dstE,
  input  logic [XLEN-1:0] M_valE,
  input  logic [3:0]      W_dstM,
  input  logic [XLEN-1:0] W_valM,
  input  logic [3:0]      W_dstE,
  input  logic [XLEN-1:0] W_valE,
  input  logic            E_stall,
  input  logic            E_bubble,
  output logic [3:0]      d_srcA,
  output logic [3:0]      d_srcB,
  output logic            load_use,
  output logic [2:0]      E_stat,
  output logic [3:0]      E_icode,
  output logic [3:0]      E_ifun,
  output logic [3:0]      E_dstE,
  output logic [3:0]      E_dstM,
  output logic [3:0]      E_srcA,
  output logic [3:0]      E_srcB,
  output logic [XLEN-1:0] E_valC,
  output logic [XLEN-1:0] E_valA,
  output logic [XLEN-1:0] E_valB
);

  logic [3:0]      d_dst_e, d_dst_m;
  logic [XLEN-1:0] rf_val_a, rf_val_b;
  logic [XLEN-1:0] d_val_a, d_val_b;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  y86_regfile #(
    .XLEN    (XLEN),
    .NREG    (NREG),
    .RSP_RST (XLEN'(RSP_RST))
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (d_srcA),
    .raddr_b (d_srcB),
    .rdata_a (rf_val_a),
    .rdata_b (rf_val_b),
    .wdst_e  (W_dstE),
    .wval_e  (W_valE),
    .wdst_m  (W_dstM),
    .wval_m  (W_valM)
  );

  // ---------------------------------------------------------------------------
  // Source / destination decode
  // ---------------------------------------------------------------------------
  always_comb begin
    d_srcA  = RNONE;
    d_srcB  = RNONE;
    d_dst_e = RNONE;
    d_dst_m = RNONE;
    case (D_icode)
      IRRMOVQ: begin
        d_srcA  = D_rA;
        d_dst_e = D_rB;
      end
      IIRMOVQ: begin
        d_dst_e = D_rB;
      end
      IRMMOVQ: begin
        d_srcA = D_rA;
        d_srcB = D_rB;
      end
      IMRMOVQ: begin
        d_srcB  = D_rB;
        d_dst_m = D_rA;
      end
      IOPQ: begin
        d_srcA  = D_rA;
        d_srcB  = D_rB;
        d_dst_e = D_rB;
      end
      ICALL: begin
        d_srcB  = RRSP;
        d_dst_e = RRSP;
      end
      IRET: begin
        d_srcA  = RRSP;
        d_srcB  = RRSP;
        d_dst_e = RRSP;
      end
      IPUSHQ: begin
        d_srcA  = D_rA;
        d_srcB  = RRSP;
        d_dst_e = RRSP;
      end
      IPOPQ: begin
        d_srcA  = RRSP;
        d_srcB  = RRSP;
        d_dst_e = RRSP;
        d_dst_m = D_rA;
      end
      default: ;  // halt, nop, jXX and illegal codes use no registers
    endcase
  end

  // ---------------------------------------------------------------------------
  // Forwarding: youngest producer first; RNONE must never match a stage's RNONE dst.
  // ---------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] fwd(input logic [3:0]      src,
                                          input logic [XLEN-1:0] rf_val);
    if (src == RNONE)       return '0;
    else if (src == e_dstE) return e_valE;
    else if (src == M_dstM) return m_valM;
    else if (src == M_dstE) return M_valE;
    else if (src == W_dstM) return W_valM;
    else if (src == W_dstE) return W_valE;
    else                    return rf_val;
  endfunction

  always_comb begin
    // call and jXX carry valP down the pipe in valA
    if ((D_icode == ICALL) || (D_icode == IJXX)) begin
      d_val_a = D_valP;
    end else begin
      d_val_a = fwd(d_srcA, rf_val_a);
    end
    d_val_b = fwd(d_srcB, rf_val_b);
  end

  // ---------------------------------------------------------------------------
  // D->E pipeline register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || E_bubble) begin
      E_stat  <= SAOK;
      E_icode <= INOP;
      E_ifun  <= 4'h0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
    end else if (!E_stall) begin
      E_stat  <= D_stat;
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_dstE  <= d_dst_e;
      E_dstM  <= d_dst_m;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
      E_valC  <= D_valC;
      E_valA  <= d_val_a;
      E_valB  <= d_val_b;
    end
  end

  // ---------------------------------------------------------------------------
  // Load/use hazard
  // ---------------------------------------------------------------------------
  assign load_use = is_load(E_icode) && (E_dstM != RNONE) &&
                    ((E_dstM == d_srcA) || (E_dstM == d_srcB));

endmodule

// File: tb/tb_decode_fwd_stage.sv
// Directed bench for decode_fwd_stage: hand-computed vectors for decode, forwarding,
// register-file writes, load/use and E register stall/bubble/reset.
module tb_decode_fwd_stage;

  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      D_stat;
  logic [3:0]      D_icode, D_ifun, D_rA, D_rB;
  logic [XLEN-1:0] D_valC, D_valP;
  logic [3:0]      e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
  logic [XLEN-1:0] e_valE, m_valM, M_valE, W_valM, W_valE;
  logic            E_stall, E_bubble;
  logic [3:0]      d_srcA, d_srcB;
  logic            load_use;
  logic [2:0]      E_stat;
  logic [3:0]      E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [XLEN-1:0] E_valC, E_valA, E_valB;

  int n_vec = 0;
  int n_err = 0;

  decode_fwd_stage #(
    .XLEN    (XLEN),
    .NREG    (15),
    .RSP_RST (255)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .D_stat   (D_stat),
    .D_icode  (D_icode),
    .D_ifun   (D_ifun),
    .D_rA     (D_rA),
    .D_rB     (D_rB),
    .D_valC   (D_valC),
    .D_valP   (D_valP),
    .e_dstE   (e_dstE),
    .e_valE   (e_valE),
    .M_dstM   (M_dstM),
    .m_valM   (m_valM),
    .M_dstE   (M_dstE),
    .M_valE   (M_valE),
    .W_dstM   (W_dstM),
    .W_valM   (W_valM),
    .W_dstE   (W_dstE),
    .W_valE   (W_valE),
    .E_stall  (E_stall),
    .E_bubble (E_bubble),
    .d_srcA   (d_srcA),
    .d_srcB   (d_srcB),
    .load_use (load_use),
    .E_stat   (E_stat),
    .E_icode  (E_icode),
    .E_ifun   (E_ifun),
    .E_dstE   (E_dstE),
    .E_dstM   (E_dstM),
    .E_srcA   (E_srcA),
    .E_srcB   (E_srcB),
    .E_valC   (E_valC),
    .E_valA   (E_valA),
    .E_valB   (E_valB)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; sample 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [3:0] icode, input logic [3:0] ifun, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] valc, input logic [63:0] valp);
    D_stat  = 3'h1;
    D_icode = icode;
    D_ifun  = ifun;
    D_rA    = ra;
    D_rB    = rb;
    D_valC  = valc;
    D_valP  = valp;
  endtask

  task automatic clear_fwd();
    e_dstE = 4'hF; e_valE = '0;
    M_dstM = 4'hF; m_valM = '0;
    M_dstE = 4'hF; M_valE = '0;
    W_dstM = 4'hF; W_valM = '0;
    W_dstE = 4'hF; W_valE = '0;
  endtask

  initial begin
    rst = 1'b1; E_stall = 1'b0; E_bubble = 1'b0;
    clear_fwd();
    set_d(4'h1, 4'h0, 4'hF, 4'hF, '0, '0);

    // 1: reset, then read %rsp and zeroed registers
    tick();
    rst = 1'b0;
    check_eq("rst_icode", E_icode, 64'h1);
    check_eq("rst_stat", E_stat, 64'h1);
    check_eq("rst_dstE", E_dstE, 64'hF);
    check_eq("rst_srcA", E_srcA, 64'hF);
    check_eq("rst_valA", E_valA, 64'h0);
    check_eq("rst_load_use", load_use, 64'h0);
    set_d(4'hB, 4'h0, 4'h0, 4'hF, '0, '0);  // popq %rax
    tick();
    check_eq("popq_valA", E_valA, 64'd255);
    check_eq("popq_valB", E_valB, 64'd255);
    check_eq("popq_dstM", E_dstM, 64'h0);
    check_eq("popq_srcA", E_srcA, 64'h4);
    set_d(4'h6, 4'h0, 4'h1, 4'h2, '0, '0);  // addq %rcx,%rdx
    tick();
    check_eq("zero_valA", E_valA, 64'h0);
    check_eq("zero_valB", E_valB, 64'h0);

    // 2: simultaneous writes to reg 3, valM wins
    set_d(4'h1, 4'h0, 4'hF, 4'hF, '0, '0);
    W_dstE = 4'h3; W_valE = 64'd7; W_dstM = 4'h3; W_valM = 64'd9;
    tick();
    clear_fwd();
    set_d(4'h2, 4'h0, 4'h3, 4'h5, '0, '0);  // rrmovq %rbx,%rbp
    tick();
    check_eq("wr_prio_valA", E_valA, 64'd9);
    check_eq("rrmov_dstE", E_dstE, 64'h5);
    check_eq("rrmov_srcB", E_srcB, 64'hF);

    // 3: forwarding priority
    e_dstE = 4'h2; e_valE = 64'd5;
    M_dstE = 4'h2; M_valE = 64'd6;
    W_dstE = 4'h3; W_valE = 64'd8;
    set_d(4'h6, 4'h1, 4'h2, 4'h3, '0, '0);
    tick();
    check_eq("fwd_e_valA", E_valA, 64'd5);
    check_eq("fwd_W_valB", E_valB, 64'd8);
    check_eq("opq_ifun", E_ifun, 64'h1);
    check_eq("opq_dstE", E_dstE, 64'h3);
    clear_fwd();
    M_dstM = 4'h2; m_valM = 64'h11; M_dstE = 4'h2; M_valE = 64'd6;
    W_dstM = 4'h6; W_valM = 64'h22; W_dstE = 4'h6; W_valE = 64'h33;
    set_d(4'h6, 4'h0, 4'h2, 4'h6, '0, '0);
    tick();
    check_eq("fwd_Mm_valA", E_valA, 64'h11);
    check_eq("fwd_Wm_valB", E_valB, 64'h22);
    clear_fwd();
    set_d(4'h2, 4'h0, 4'h6, 4'h0, '0, '0);
    tick();
    check_eq("rf_r6_valA", E_valA, 64'h22);

    // 4: valP path, ret, RNONE never forwards, illegal icode
    set_d(4'h8, 4'h0, 4'hF, 4'hF, 64'h100, 64'h40);  // call
    tick();
    check_eq("call_valA", E_valA, 64'h40);
    check_eq("call_srcB", E_srcB, 64'h4);
    check_eq("call_dstE", E_dstE, 64'h4);
    check_eq("call_valB", E_valB, 64'd255);
    set_d(4'h7, 4'h3, 4'hF, 4'hF, 64'h200, 64'h99);  // jXX
    tick();
    check_eq("jxx_valA", E_valA, 64'h99);
    check_eq("jxx_srcA", E_srcA, 64'hF);
    set_d(4'h9, 4'h0, 4'hF, 4'hF, '0, '0);  // ret
    tick();
    check_eq("ret_valA", E_valA, 64'd255);
    e_dstE = 4'hF; e_valE = 64'hDEAD;
    set_d(4'h3, 4'h0, 4'hF, 4'h7, 64'h1234, '0);  // irmovq
    tick();
    check_eq("rnone_valA", E_valA, 64'h0);
    check_eq("irmov_valC", E_valC, 64'h1234);
    check_eq("irmov_dstE", E_dstE, 64'h7);
    clear_fwd();
    set_d(4'hC, 4'h0, 4'h1, 4'h2, '0, '0);
    #1;
    check_eq("ill_srcA", d_srcA, 64'hF);
    check_eq("ill_srcB", d_srcB, 64'hF);
    tick();
    check_eq("ill_dstE", E_dstE, 64'hF);
    check_eq("ill_dstM", E_dstM, 64'hF);

    // 5: load/use
    set_d(4'h5, 4'h0, 4'h1, 4'h2, '0, '0);  // mrmovq -> dstM=1
    tick();
    set_d(4'h6, 4'h0, 4'h1, 4'h3, '0, '0);
    #1;
    check_eq("lu_srcA", load_use, 64'h1);
    check_eq("d_srcA", d_srcA, 64'h1);
    set_d(4'h6, 4'h0, 4'h5, 4'h6, '0, '0);
    #1;
    check_eq("lu_none", load_use, 64'h0);
    set_d(4'h6, 4'h0, 4'h4, 4'h1, '0, '0);
    #1;
    check_eq("lu_srcB", load_use, 64'h1);
    E_bubble = 1'b1;
    tick();
    E_bubble = 1'b0;
    check_eq("bub_icode", E_icode, 64'h1);
    check_eq("bub_dstM", E_dstM, 64'hF);
    check_eq("bub_load_use", load_use, 64'h0);
    set_d(4'hB, 4'h0, 4'hF, 4'hF, '0, '0);  // popq with rA=RNONE
    tick();
    set_d(4'h6, 4'h0, 4'hF, 4'hF, '0, '0);
    #1;
    check_eq("lu_rnone", load_use, 64'h0);

    // 6: stall holds E, regfile still written; stall+bubble gives bubble
    set_d(4'h3, 4'h0, 4'hF, 4'h7, 64'h77, '0);
    tick();
    E_stall = 1'b1;
    W_dstE = 4'h9; W_valE = 64'hAB;
    for (int i = 0; i < 3; i++) begin
      set_d(4'h6, 4'(i), 4'(i), 4'(i + 1), 64'(i + 100), '0);
      tick();
      W_dstE = 4'hF;
      check_eq("stall_icode", E_icode, 64'h3);
      check_eq("stall_valC", E_valC, 64'h77);
      check_eq("stall_dstE", E_dstE, 64'h7);
    end
    E_bubble = 1'b1;
    tick();
    E_stall = 1'b0; E_bubble = 1'b0;
    check_eq("stbub_icode", E_icode, 64'h1);
    check_eq("stbub_dstE", E_dstE, 64'hF);
    set_d(4'h2, 4'h0, 4'h9, 4'h1, '0, '0);
    tick();
    check_eq("stall_wr_valA", E_valA, 64'hAB);

    // reset beats stall and clears the regfile
    set_d(4'h3, 4'h0, 4'hF, 4'h7, 64'h55, '0);
    tick();
    rst = 1'b1; E_stall = 1'b1;
    tick();
    rst = 1'b0; E_stall = 1'b0;
    check_eq("rst_stall_icode", E_icode, 64'h1);
    set_d(4'h2, 4'h0, 4'h9, 4'h1, '0, '0);
    tick();
    check_eq("rst_r9_valA", E_valA, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
